// File: rtl/jtpopeye_obj_draw.sv
// jtpopeye_obj_draw: turns object line-buffer entries into pixels.
// Each 4-pixel slot may deliver one entry. The entry's ROM row is fetched and
// then loaded into one of two ping-pong drawers. The drawers shift out their
// pixels, and a registered mixer gives priority to the older drawer.

// One drawer: holds a fetched 2bpp row and plays it out after its start delay.
module jtpopeye_obj_drawer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pxl_cen,
  input  logic        slot_start,
  input  logic        hb,
  input  logic        load,
  input  logic [15:0] ld_data,
  input  logic [2:0]  ld_pal,
  input  logic        ld_hflip,
  input  logic [1:0]  ld_off,
  output logic        active,
  output logic [4:0]  pxl
);
  logic [7:0] hi, lo;
  logic [2:0] pal;
  logic       hflip;
  logic [1:0] off, wcnt;
  logic       started, emit;
  logic [2:0] cnt, pos;

  // Drawer sequencing: wait for a slot start, count out the offset, emit 8 pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0; lo <= '0; pal <= '0; hflip <= 1'b0; off <= '0;
      active <= 1'b0; started <= 1'b0; emit <= 1'b0; wcnt <= '0; cnt <= '0;
    end else if (hb) begin
      active <= 1'b0; started <= 1'b0; emit <= 1'b0;
    end else if (load) begin
      // A reload always restarts the drawer, even if it was mid-object.
      hi <= ld_data[15:8]; lo <= ld_data[7:0];
      pal <= ld_pal; hflip <= ld_hflip; off <= ld_off;
      active <= 1'b1; started <= 1'b0; emit <= 1'b0; wcnt <= '0; cnt <= '0;
    end else if (pxl_cen && active) begin
      if (!started) begin
        if (slot_start) begin
          started <= 1'b1;
          if (off == 2'd0) emit <= 1'b1;
          else wcnt <= off;
        end
      end else if (!emit) begin
        wcnt <= wcnt - 2'd1;
        if (wcnt == 2'd1) emit <= 1'b1;
      end else begin
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          active <= 1'b0;
          emit   <= 1'b0;
        end
      end
    end
  end

  // Pixel i normally comes from bit 7-i of each plane; hflip reverses the order.
  always_comb begin
    pos = hflip ? cnt : ~cnt;
    pxl = emit ? {pal, hi[pos], lo[pos]} : 5'd0;
  end
endmodule

module jtpopeye_obj_draw (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic [7:0]  H,
  input  logic        HB,
  input  logic [17:0] DJ,
  output logic        rom_cs,
  output logic [10:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        rom_ok,
  output logic [4:0]  obj_pxl,
  output logic        miss
);
  localparam int ND = 2;

  typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

  typedef struct packed {
    logic [2:0] pal;
    logic       hflip;
    logic [1:0] off;
  } ent_t;

  state_t                st, st_nxt;
  ent_t                  ent;
  logic                  cap, cap_ok, miss_d, load_d, ovr, nxt_b;
  logic [15:0]           ld_data;
  logic [ND-1:0]         d_act, d_ld;
  logic [ND-1:0][4:0]    d_pxl;
  logic [4:0]            old_p, new_p, mix;
  logic [6:0]            unused_bits;

  // vflip is already folded into sub-V; only the low H bits pick the slot phase.
  assign unused_bits = {DJ[0], H[7:2]};

  assign cap    = pxl_cen && (H[1:0] == 2'b01) && !HB;
  assign cap_ok = cap && (DJ[16:14] != 3'd0);

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Fetch FSM next state and strobes.
  always_comb begin
    st_nxt = st;
    rom_cs = 1'b0;
    miss_d = 1'b0;
    load_d = 1'b0;
    case (st)
      IDLE: if (cap_ok) st_nxt = REQ;
      REQ: begin
        rom_cs = 1'b1;
        if (cap) begin
          // ROM too slow: drop the pending entry in favour of the new slot.
          miss_d = 1'b1;
          st_nxt = cap_ok ? REQ : IDLE;
        end else if (rom_ok) begin
          st_nxt = LOAD;
        end
      end
      LOAD: begin
        load_d = 1'b1;
        st_nxt = cap_ok ? REQ : IDLE;
      end
      default: st_nxt = IDLE;
    endcase
    if (HB) begin
      st_nxt = IDLE;
      rom_cs = 1'b0;
      miss_d = 1'b0;
      load_d = 1'b0;
    end
  end

  assign d_ld = load_d ? (nxt_b ? 2'b10 : 2'b01) : 2'b00;
  assign ovr  = |(d_ld & d_act);

  // Entry capture, ROM row latch, miss pulse and drawer alternation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      ent      <= '0;
      ld_data  <= '0;
      miss     <= 1'b0;
      nxt_b    <= 1'b0;
    end else begin
      miss <= miss_d | ovr;
      if (cap_ok) begin
        rom_addr <= {DJ[17], DJ[10:4], DJ[3:1]};
        ent      <= '{pal: DJ[16:14], hflip: DJ[11], off: DJ[13:12]};
      end
      if (st == REQ && rom_ok && !cap && !HB) ld_data <= rom_data;
      if (HB)          nxt_b <= 1'b0;
      else if (load_d) nxt_b <= ~nxt_b;
    end
  end

  for (genvar g = 0; g < ND; g++) begin : g_drw
    jtpopeye_obj_drawer u_drw (
      .clk        (clk),
      .rst_n      (rst_n),
      .pxl_cen    (pxl_cen),
      .slot_start (H[1:0] == 2'b00),
      .hb         (HB),
      .load       (d_ld[g]),
      .ld_data    (ld_data),
      .ld_pal     (ent.pal),
      .ld_hflip   (ent.hflip),
      .ld_off     (ent.off),
      .active     (d_act[g]),
      .pxl        (d_pxl[g])
    );
  end

  // The drawer due to be loaded next is the older one; it has priority.
  always_comb begin
    old_p = nxt_b ? d_pxl[1] : d_pxl[0];
    new_p = nxt_b ? d_pxl[0] : d_pxl[1];
    if (old_p[1:0] != 2'd0)      mix = old_p;
    else if (new_p[1:0] != 2'd0) mix = new_p;
    else                         mix = 5'd0;
  end

  // Registered pixel output, blanked during HB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       obj_pxl <= '0;
    else if (HB)      obj_pxl <= '0;
    else if (pxl_cen) obj_pxl <= mix;
  end
endmodule

// File: doc/jtpopeye_obj_draw.md
JTPOPEYE_OBJ_DRAW -- requirements
Module: jtpopeye_obj_draw

Interface
REQ-001 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have port clk  in  1  single system clock; all state on posedge clk.
REQ-003 SHALL have port pxl_cen  in  1  pixel clock enable.
REQ-004 SHALL have port H  in  8  horizontal pixel count.
REQ-005 SHALL have port HB  in  1  horizontal blank, high = blank.
REQ-006 SHALL have port DJ  in  18  line-buffer entry: {DJ[17],DJ[10:4]} object ID, DJ[16:14] palette (0 = empty), DJ[13:12] start offset, DJ[11] hflip, DJ[3:1] sub-V, DJ[0] vflip (already applied to sub-V; ignored).
REQ-007 SHALL have port rom_cs  out  1  object ROM request.
REQ-008 SHALL have port rom_addr  out  11  = {objid[7:0], subV[2:0]}.
REQ-009 SHALL have port rom_data  in  16  2bpp row: [15:8] plane 1, [7:0] plane 0.
REQ-010 SHALL have port rom_ok  in  1  rom_data valid for current rom_addr.
REQ-011 SHALL have port obj_pxl  out  5  {palette, colour}; colour 0 = transparent.
REQ-012 SHALL have port miss  out  1  one-clk pulse when an entry is dropped.

Function
REQ-013 Slot = 4 pixels (H[1:0]); entry SHALL be captured on pxl_cen with H[1:0]==2'b01 and HB low.
REQ-014 Captured entry with palette 0 SHALL be discarded silently (no ROM request, no miss).
REQ-015 FSM states IDLE, REQ, LOAD: IDLE->REQ on valid capture; REQ holds rom_cs=1 with rom_addr stable until rom_ok; REQ->LOAD on rom_ok; LOAD->IDLE next clk after loading a drawer.
REQ-016 If still in REQ at the next capture point, SHALL pulse miss, abandon old entry, and start REQ for the new entry in the same clk.
REQ-017 Two drawers A/B SHALL be loaded alternately (A first after reset/HB); each holds 8 pixels, palette, hflip, offset, and an active flag.
REQ-018 Drawer SHALL start emitting at the first pxl_cen with H[1:0]==2'b00 after load plus DJ[13:12] further pixel periods, then shift one pixel per pxl_cen for 8 pixels, then go inactive.
REQ-019 Pixel order: hflip=0 -> pixel i = {rom_data[15-i], rom_data[7-i]}; hflip=1 -> i replaced by 7-i.
REQ-020 Loading a drawer still active SHALL overwrite it (newest wins), with miss pulse.
REQ-021 Mixing: older active drawer with non-zero colour SHALL win; else newer drawer; else obj_pxl=0.
REQ-022 obj_pxl SHALL be registered, updated only on pxl_cen, one pixel period after drawer selection.
REQ-023 While HB high: obj_pxl=0, both drawers inactive, FSM forced to IDLE, rom_cs=0, A/B alternation reset to A.
REQ-024 H wrap 255->0 SHALL need no special handling beyond HB.

Reset
REQ-025 On rst_n low, asynchronously: FSM IDLE, rom_cs=0, rom_addr=0, obj_pxl=0, miss=0, drawers inactive, alternation = A.
REQ-026 Reset mid-request SHALL drop the request without miss pulse.

Verification
REQ-027 DJ={id 0x45, pal 3, off 0, hflip 0, subV 5}, rom_ok 1 clk after rom_cs, rom_data=0xF00F -> rom_addr=0x22D; 8 pixels after next slot start: 2,2,2,2,1,1,1,1 with palette 3 (obj_pxl 0x0E x4, 0x0D x4).
REQ-028 Same entry, hflip=1 -> pixels 1,1,1,1,2,2,2,2.
REQ-029 Offset 3, rom_data=0xFFFF -> first obj_pxl 0x1F (pal 7) appears 3 pixels later than offset 0 case.
REQ-030 rom_ok withheld past next capture -> miss pulses once, second entry fetched, first never drawn.
REQ-031 Palette-0 entry -> no rom_cs, no miss, obj_pxl stays 0.
REQ-032 Two overlapping objects, older colour 0 at pixel -> newer colour shown; older non-zero -> older shown; HB asserted mid-draw -> obj_pxl 0 next pxl_cen.
